// File: rtl/vga_sync_generator.sv
// VGA timing generator: pixel divider, h/v counters with porch FSMs, registered syncs.
// Define VGA_SYNC_ALIGN_EN to delay hsync/vsync by one clk_in to match a registered colour path.
module vga_sync_generator #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk_in,
  input  logic       rst_in,
  output logic [9:0] current_row,
  output logic [9:0] current_line,
  output logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic       pixel_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT_END    = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT_END    = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [4:0] DIV_LAST     = 5'(CLK_DIV - 1);

  typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} h_state_t;
  typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} v_state_t;

  h_state_t   h_state, h_state_next;
  v_state_t   v_state, v_state_next;
  logic [4:0] div_q;
  logic [9:0] h_q, v_q, h_next, v_next;
  logic       advance, h_wrap, v_wrap;
  logic       hsync_q, vsync_q;

  always_comb begin
    advance = (div_q == DIV_LAST);
    h_wrap  = advance && (h_q == H_LAST);
    v_wrap  = h_wrap && (v_q == V_LAST);
    h_next  = h_q;
    v_next  = v_q;
    if (advance) begin
      h_next = h_wrap ? 10'd0 : h_q + 10'd1;
    end
    if (h_wrap) begin
      v_next = v_wrap ? 10'd0 : v_q + 10'd1;
    end
  end

  // Porch FSMs follow the next-state counters so the registered syncs line up with them.
  always_comb begin
    h_state_next = h_state;
    if (advance) begin
      case (h_state)
        HS_ACT:  if (h_next == H_ACT_END)    h_state_next = HS_FP;
        HS_FP:   if (h_next == H_SYNC_START) h_state_next = HS_SYNC;
        HS_SYNC: if (h_next == H_SYNC_END)   h_state_next = HS_BP;
        HS_BP:   if (h_next == 10'd0)        h_state_next = HS_ACT;
        default: h_state_next = HS_ACT;
      endcase
    end
  end

  always_comb begin
    v_state_next = v_state;
    if (h_wrap) begin
      case (v_state)
        VS_ACT:  if (v_next == V_ACT_END)    v_state_next = VS_FP;
        VS_FP:   if (v_next == V_SYNC_START) v_state_next = VS_SYNC;
        VS_SYNC: if (v_next == V_SYNC_END)   v_state_next = VS_BP;
        VS_BP:   if (v_next == 10'd0)        v_state_next = VS_ACT;
        default: v_state_next = VS_ACT;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_q       <= 5'd0;
      h_q         <= 10'd0;
      v_q         <= 10'd0;
      h_state     <= HS_ACT;
      v_state     <= VS_ACT;
      enable      <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_q       <= advance ? 5'd0 : div_q + 5'd1;
      h_q         <= h_next;
      v_q         <= v_next;
      h_state     <= h_state_next;
      v_state     <= v_state_next;
      enable      <= (h_next < H_ACT_END) && (v_next < V_ACT_END);
      hsync_q     <= (h_state_next != HS_SYNC);
      vsync_q     <= (v_state_next != VS_SYNC);
      pixel_tick  <= advance;
      frame_start <= v_wrap;
    end
  end

  assign current_row  = h_q;
  assign current_line = v_q;

`ifdef VGA_SYNC_ALIGN_EN
  logic hsync_d, vsync_d;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hsync_d <= 1'b1;
      vsync_d <= 1'b1;
    end else begin
      hsync_d <= hsync_q;
      vsync_d <= vsync_q;
    end
  end

  assign hsync = hsync_d;
  assign vsync = vsync_d;
`else
  assign hsync = hsync_q;
  assign vsync = vsync_q;
`endif

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: two small-timing instances (CLK_DIV 3 and 1) checked every
// cycle against an arithmetic model of elapsed clocks since reset, plus literal frame pins.
module tb_vga_sync_generator;

  localparam int HA = 20, HF = 3, HS = 5, HB = 4;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int DA = 3;
  localparam int DB = 1;
`ifdef VGA_SYNC_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [9:0] a_row, a_line, b_row, b_line;
  logic       a_en, a_hs, a_vs, a_pt, a_fs;
  logic       b_en, b_hs, b_vs, b_pt, b_fs;

  int errors  = 0;
  int checks  = 0;
  int k       = 0;
  bit started = 1'b0;

  vga_sync_generator #(
    .CLK_DIV(DA), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut_a (
    .clk_in(clk_in), .rst_in(rst_in),
    .current_row(a_row), .current_line(a_line),
    .enable(a_en), .hsync(a_hs), .vsync(a_vs),
    .pixel_tick(a_pt), .frame_start(a_fs)
  );

  vga_sync_generator #(
    .CLK_DIV(DB), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut_b (
    .clk_in(clk_in), .rst_in(rst_in),
    .current_row(b_row), .current_line(b_line),
    .enable(b_en), .hsync(b_hs), .vsync(b_vs),
    .pixel_tick(b_pt), .frame_start(b_fs)
  );

  always #5 clk_in = ~clk_in;

  // k = clk_in edges since the last reset edge; everything the DUT shows follows from it
  always @(posedge clk_in) k <= rst_in ? 0 : k + 1;

  function automatic int hsAt(input int d, input int kk);
    int h;
    if (kk <= 0) return 1;
    h = (kk / d) % HT;
    return (h >= HA + HF && h < HA + HF + HS) ? 0 : 1;
  endfunction

  function automatic int vsAt(input int d, input int kk);
    int v;
    if (kk <= 0) return 1;
    v = ((kk / d) / HT) % VT;
    return (v >= VA + VF && v < VA + VF + VS) ? 0 : 1;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic checkInstance(input string tag, input int d, input logic [9:0] row,
                               input logic [9:0] line, input logic en, input logic hs,
                               input logic vs, input logic pt, input logic fs);
    int p, h, v, tick;
    p    = k / d;
    h    = p % HT;
    v    = (p / HT) % VT;
    tick = (k > 0 && k % d == 0) ? 1 : 0;
    checkOutput({tag, ".row"}, int'(row), h);
    checkOutput({tag, ".line"}, int'(line), v);
    checkOutput({tag, ".enable"}, int'(en), (k > 0 && h < HA && v < VA) ? 1 : 0);
    checkOutput({tag, ".hsync"}, int'(hs), ALIGN ? hsAt(d, k - 1) : hsAt(d, k));
    checkOutput({tag, ".vsync"}, int'(vs), ALIGN ? vsAt(d, k - 1) : vsAt(d, k));
    checkOutput({tag, ".pixel_tick"}, int'(pt), tick);
    checkOutput({tag, ".frame_start"}, int'(fs), (tick == 1 && p % (HT * VT) == 0) ? 1 : 0);
  endtask

  always @(negedge clk_in) begin
    if (started) begin
      checkInstance("A", DA, a_row, a_line, a_en, a_hs, a_vs, a_pt, a_fs);
      checkInstance("B", DB, b_row, b_line, b_en, b_hs, b_vs, b_pt, b_fs);
    end
  end

  task automatic applyStimulus(input logic rst, input int cycles);
    repeat (cycles) begin
      @(posedge clk_in);
      #2;
      rst_in = rst;
    end
  endtask

  task automatic waitRowLine(input int row, input int line);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_in);
      if (int'(a_row) == row && (line < 0 || int'(a_line) == line)) return;
    end
    checkOutput("wait_row_line_timeout", 0, 1);
  endtask

  task automatic measureFrame(input int which, output int period, output int hsLow,
                              output int vsLow, output int ticks);
    bit seen;
    period = 0; hsLow = 0; vsLow = 0; ticks = 0;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk_in);
      seen = (which == 0) ? a_fs : b_fs;
    end
    if (!seen) begin
      checkOutput("frame_wait_timeout", 0, 1);
      return;
    end
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk_in);
      period++;
      if (((which == 0) ? a_hs : b_hs) == 1'b0) hsLow++;
      if (((which == 0) ? a_vs : b_vs) == 1'b0) vsLow++;
      if (((which == 0) ? a_pt : b_pt) == 1'b1) ticks++;
      seen = (which == 0) ? a_fs : b_fs;
    end
  endtask

  initial begin
    int period, hsLow, vsLow, ticks;
    rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #2;
    started = 1'b1;

    @(negedge clk_in);
    checkOutput("reset_enable", int'(a_en), 0);
    checkOutput("reset_hsync", int'(a_hs), 1);
    checkOutput("reset_row", int'(a_row), 0);
    rst_in = 1'b0;
    @(negedge clk_in);
    checkOutput("release_enable", int'(a_en), 1);
    checkOutput("release_b_tick", int'(b_pt), 1);

    waitRowLine(HA - 1, 0);
    checkOutput("last_active_enable", int'(a_en), 1);
    waitRowLine(HA, 0);
    checkOutput("first_porch_enable", int'(a_en), 0);
    waitRowLine(HA + HF, -1);
    checkOutput("hsync_at_sync_start", int'(a_hs), ALIGN ? 1 : 0);
    @(negedge clk_in);
    checkOutput("hsync_after_sync_start", int'(a_hs), 0);

    measureFrame(0, period, hsLow, vsLow, ticks);
    checkOutput("A.frame_period", period, 1632);
    checkOutput("A.hsync_low_cycles", hsLow, 255);
    checkOutput("A.vsync_low_cycles", vsLow, 192);
    checkOutput("A.ticks_per_frame", ticks, 544);

    measureFrame(1, period, hsLow, vsLow, ticks);
    checkOutput("B.frame_period", period, 544);
    checkOutput("B.hsync_low_cycles", hsLow, 85);
    checkOutput("B.vsync_low_cycles", vsLow, 64);
    checkOutput("B.ticks_per_frame", ticks, 544);

    waitRowLine(10, 5);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 1);
    @(negedge clk_in);
    checkOutput("midreset_row", int'(a_row), 0);
    checkOutput("midreset_line", int'(a_line), 0);
    checkOutput("midreset_enable", int'(a_en), 0);
    checkOutput("midreset_vsync", int'(a_vs), 1);
    checkOutput("midreset_frame_start", int'(a_fs), 0);
    @(negedge clk_in);
    checkOutput("midreset_enable_back", int'(a_en), 1);
    checkOutput("midreset_no_frame_start", int'(a_fs), 0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, int'($urandom_range(50, 1800)));
      applyStimulus(1'b1, int'($urandom_range(1, 3)));
    end
    applyStimulus(1'b0, 200);

    @(negedge clk_in);
    started = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_generator.md
VGA_SYNC_GENERATOR -- requirements
Module: vga_sync_generator

Interface
REQ-001 Parameter CLK_DIV, default 4: clk_in cycles per pixel, legal range 1..16.
REQ-002 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-003 Parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48: horizontal front porch, sync and back porch widths in pixels.
REQ-004 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-005 Parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33: vertical front porch, sync and back porch widths in lines.
REQ-006 clk_in  input  1  single system clock; all logic on its rising edge.
REQ-007 rst_in  input  1  synchronous, active-high reset.
REQ-008 current_row  output  10  horizontal pixel counter h, 0..H_TOTAL-1, where H_TOTAL = sum of the four horizontal parameters (800 by default).
REQ-009 current_line  output  10  vertical line counter v, 0..V_TOTAL-1, where V_TOTAL = sum of the four vertical parameters (525 by default).
REQ-010 enable  output  1  high iff h < H_ACTIVE and v < V_ACTIVE.
REQ-011 hsync  output  1  active-low horizontal sync.
REQ-012 vsync  output  1  active-low vertical sync.
REQ-013 pixel_tick  output  1  one-clk_in strobe marking a pixel advance.
REQ-014 frame_start  output  1  one-clk_in strobe on the wrap to (0,0).

Function
REQ-015 A divider counter SHALL run 0..CLK_DIV-1.
  - pixel_tick SHALL be registered and high for exactly the one cycle after the divider reaches CLK_DIV-1.
  - With CLK_DIV=1, pixel_tick SHALL be high on every cycle after reset.
REQ-016 On each clk_in edge with a pixel advance:
  - h SHALL increment.
  - At h = H_TOTAL-1, h SHALL wrap to 0 and v SHALL increment.
  - At v = V_TOTAL-1 on that same wrap, v SHALL wrap to 0.
REQ-017 Without a pixel advance, h and v SHALL hold their values.
REQ-018 A horizontal FSM H_ACT -> H_FP -> H_SYNC -> H_BP -> H_ACT SHALL track h. Transitions occur at these h values:
  - H_ACTIVE
  - H_ACTIVE+H_FP
  - H_ACTIVE+H_FP+H_SYNC
  - 0
REQ-019 A vertical FSM V_ACT -> V_FP -> V_SYNC -> V_BP -> V_ACT SHALL track v with the same boundaries from the vertical parameters. It SHALL advance only on the h wrap.
REQ-020 hsync SHALL be 0 exactly while the FSM is in H_SYNC (h 656..751 by default).
REQ-021 vsync SHALL be 0 exactly while the FSM is in V_SYNC (v 490..491 by default).
REQ-022 enable, hsync and vsync SHALL be registered and decoded from the next-state counters. They are always consistent with current_row and current_line in the same cycle.
REQ-023 frame_start SHALL be high for one clk_in cycle: the cycle in which current_row and current_line first read (0,0) after a wrap.
REQ-024 The counter arithmetic SHALL be 10-bit unsigned. No counter value SHALL ever exceed H_TOTAL-1 or V_TOTAL-1.

Reset
REQ-025 While rst_in=1, the outputs SHALL be held at these values:
  - h=0, v=0
  - divider=0
  - both FSMs in *_ACT
  - enable=0, hsync=1, vsync=1
  - pixel_tick=0, frame_start=0
REQ-026 On the first edge after rst_in falls, the outputs SHALL re-decode (0,0), giving enable=1. Counting SHALL resume from divider 0.
REQ-027 Reset asserted mid-frame SHALL take priority over any pixel advance on the same edge.

Configuration
REQ-028 Macro VGA_SYNC_ALIGN_EN:
  - When defined, hsync and vsync SHALL pass through one extra clk_in register stage (reset value 1). This matches the one-cycle registered colour path of the pixel renderer.
  - When undefined, hsync and vsync SHALL be driven directly per REQ-022.
  - Counters, enable, pixel_tick and frame_start SHALL be unaffected either way.

Verification
REQ-029 Default parameters, run 3,360,000 clk_in -> frame_start pulses exactly 1,680,000 cycles apart.
REQ-030 CLK_DIV=4 -> pixel_tick every 4th clk_in. When current_row goes 639 -> 640, enable falls in the same cycle as the counter change.
REQ-031 One line -> hsync low for exactly 96 pixel advances (384 clk_in), starting when current_row=656. One frame -> vsync low for exactly 1600 pixel advances, starting at current_line=490, current_row=0.
REQ-032 Assert rst_in for one cycle at current_row=300, current_line=200 -> the following cycles show (0,0), enable=0 then 1, hsync=vsync=1, and no frame_start pulse.
REQ-033 CLK_DIV=1 -> pixel_tick constantly high. The frame period is 420,000 clk_in.
REQ-034 VGA_SYNC_ALIGN_EN defined -> the hsync falling edge occurs one clk_in after current_row becomes 656. Undefined -> it occurs in the same cycle.
